ibox_operand_stage: RTL and testbench
=====================================

# ibox_operand_stage

Operand-fetch stage directly upstream of the integer box. Accepts a decoded integer instruction, reads two 64-bit operands from a 32-entry integer register file (R31 hard-wired to zero), forwards same-cycle writeback results, and stalls on scoreboard hazards. Presents registered `a`, `b` and the 32-bit `control` word to the integer box, which is combinational, over a valid/ready handshake. Result writeback from downstream enters through the `wb_*` port.

## Interface
- `XLEN`, 64, operand width; only 64 is supported.
- `NREGS`, 32, architectural register count; index 31 is the zero register.

Ports:
- `clk` in 1: the single clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: a decoded instruction is offered.
- `in_ready` out 1: the stage accepts this cycle.
- `in_ra`, `in_rb`, `in_rc` in 5: source A, source B and destination indices.
- `in_lit_valid` in 1: use the literal in place of Rb.
- `in_lit` in 8: literal, zero-extended to 64 bits.
- `in_control` in 32: integer-box control word, carried unchanged.
- `out_valid` out 1: operands are valid.
- `out_ready` in 1: the integer box and its consumer take the operands.
- `out_a`, `out_b` out 64: operands.
- `out_control` out 32: registered control word.
- `out_rc` out 5: registered destination index.
- `wb_valid` in 1: writeback strobe.
- `wb_rc` in 5: writeback destination index.
- `wb_data` in 64: writeback value.

## Operation
- **Register file:** 31 × 64 storage.
  - Writes happen at the clock edge when `wb_valid` is high and `wb_rc`≠31.
  - Reads of index 31 return 0. Writes to index 31 are ignored.
  - Storage is not reset. A read before the first write returns an undefined value, except index 31.
- **Scoreboard:** one busy bit per register 0–30.
  - Set on accept when `in_rc`≠31.
  - Cleared when `wb_valid` is high and `wb_rc` matches.
  - When set and clear hit the same index in the same cycle, the set wins.
- **Hazard:** raised when any of the following is busy and not cleared this cycle by `wb`:
  - `in_ra`;
  - `in_rb`, when `in_lit_valid` is 0;
  - `in_rc`. This is the write-after-write stall; only one producer per register may be outstanding.
- **Ready:** `in_ready` = (`out_valid`==0 | `out_ready`) & ~hazard.
  - `in_ready` may depend combinationally on `in_valid`-side fields, `out_ready` and `wb_*`.
  - `in_ready` is 0 while `reset` is high.
- **Accept** (`in_valid` & `in_ready`):
  - Load `out_a`, `out_b`, `out_control` and `out_rc`; set `out_valid`.
  - `out_b` = {56'b0, `in_lit`} when `in_lit_valid` is 1.
- **Bypass:** an operand read whose index equals `wb_rc` (with `wb_valid` high and index≠31) takes `wb_data` instead of the file contents.
- **Drain:** `out_valid` & `out_ready` with no new accept clears `out_valid`.
- **Hold:** while `out_valid` is high and `out_ready` is low, all `out_*` hold stable.

## Timing
- **Latency:** accept in cycle N gives `out_valid`=1 in cycle N+1.
  - Throughput is one instruction per cycle when hazard-free.
- **Back-to-back:** drain and accept in the same cycle keeps `out_valid` high with the new contents.
- **Reset values:** `out_valid`=0, `out_a`=0, `out_b`=0, `out_control`=0, `out_rc`=0, all busy bits 0.
- **Reset mid-operation:** a held instruction is discarded, and a `wb` in the reset cycle still writes the file.
- **Dependent instruction:** stalls until the cycle its producer's `wb_valid` is asserted, and is accepted in that same cycle, with `IBOX_BYPASS_EN` defined.

## Configuration
- **`IBOX_BYPASS_EN` defined:** same-cycle forwarding of `wb_data` as described above, and a busy bit cleared by `wb` this cycle does not cause a hazard.
- **`IBOX_BYPASS_EN` undefined:**
  - No forwarding path.
  - The hazard ignores same-cycle clears, so a dependent instruction is accepted one cycle after its writeback and reads the updated file.
  - Busy-bit update rules are unchanged.

## Structure
- **Package `ibox_pkg`:**
  - `REG_ZERO`=5'd31, `NREGS`, `XLEN`, `CTRL_W`=32;
  - typedef `reg_idx_t` (5 bits);
  - typedef `word_t` (64 bits).
- **Sub-module `ibox_regfile`:** 2 read ports, 1 write port, zero-register handling. Scoreboard, bypass and handshake live in the top module.

## Test plan
- **Reset:** hold `reset` high for 2 cycles → all outputs 0, `in_ready`=0; release → `in_ready`=1.
- **Independent issue:** write R1=5, R2=7 via `wb`; issue ra=1, rb=2, rc=3 → next cycle `out_a`=5, `out_b`=7, `out_rc`=3; R3 busy.
- **Literal:** issue ra=31, literal 0xFF, rc=4 → `out_a`=0, `out_b`=0xFF.
- **Read-after-write hazard:** issue rc=3, then ra=3 → `in_ready`=0 until `wb` rc=3 data=0x1234.
  - With bypass: accepted in the `wb` cycle, `out_a`=0x1234.
  - Without bypass: accepted one cycle later, `out_a`=0x1234.
- **Backpressure:** `out_ready`=0 for 3 cycles → `out_*` stable, `in_ready`=0; then `out_ready`=1 with a new instruction offered → the new instruction appears with no bubble.
- **Write-after-write and zero register:**
  - Issue rc=5 twice → the second stalls until `wb` rc=5.
  - `wb` rc=31 data=9, then read R31 → 0.

Source files
------------

// File: rtl/ibox_pkg.sv
// Shared constants and types for the integer-box operand stage.
package ibox_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned CTRL_W = 32;

    typedef logic [4:0]      reg_idx_t;
    typedef logic [XLEN-1:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd31;

endpackage

// File: rtl/ibox_regfile.sv
// Integer register file: 2 read ports, 1 write port, R31 reads as zero and ignores writes.
module ibox_regfile
    import ibox_pkg::*;
(
    input  logic            clk,
    input  logic [4:0]      ra_idx,
    input  logic [4:0]      rb_idx,
    output logic [XLEN-1:0] ra_data,
    output logic [XLEN-1:0] rb_data,
    input  logic            we,
    input  logic [4:0]      wr_idx,
    input  logic [XLEN-1:0] wr_data
);

    // Only R0..R30 have storage; contents are intentionally not reset.
    word_t mem [NREGS-1];

    always_ff @(posedge clk) begin
        if (we && wr_idx != REG_ZERO) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        ra_data = '0;
        rb_data = '0;
        if (ra_idx != REG_ZERO) ra_data = mem[ra_idx];
        if (rb_idx != REG_ZERO) rb_data = mem[rb_idx];
    end

endmodule

// File: rtl/ibox_operand_stage.sv
// Operand fetch, scoreboard and valid/ready output register feeding the integer box.
// Define IBOX_BYPASS_EN to forward same-cycle writeback data and honour same-cycle busy clears.
module ibox_operand_stage
    import ibox_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_ra,
    input  logic [4:0]        in_rb,
    input  logic [4:0]        in_rc,
    input  logic              in_lit_valid,
    input  logic [7:0]        in_lit,
    input  logic [CTRL_W-1:0] in_control,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_a,
    output logic [XLEN-1:0]   out_b,
    output logic [CTRL_W-1:0] out_control,
    output logic [4:0]        out_rc,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rc,
    input  logic [XLEN-1:0]   wb_data
);

    word_t             rf_a, rf_b;
    word_t             opnd_a, opnd_b_reg, opnd_b;
    logic              wb_hit, hazard, accept;
    logic [NREGS-1:0]  busy_q, busy_d, busy_eff, clr_mask, set_mask;

    logic              valid_q, valid_d;
    word_t             a_q, a_d, b_q, b_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    reg_idx_t          rc_q, rc_d;

    ibox_regfile u_regfile (
        .clk     (clk),
        .ra_idx  (in_ra),
        .rb_idx  (in_rb),
        .ra_data (rf_a),
        .rb_data (rf_b),
        .we      (wb_valid),
        .wr_idx  (wb_rc),
        .wr_data (wb_data)
    );

    assign wb_hit   = wb_valid && (wb_rc != REG_ZERO);
    assign clr_mask = wb_hit ? (NREGS'(1) << wb_rc) : '0;

`ifdef IBOX_BYPASS_EN
    assign busy_eff   = busy_q & ~clr_mask;
    assign opnd_a     = (wb_hit && wb_rc == in_ra) ? wb_data : rf_a;
    assign opnd_b_reg = (wb_hit && wb_rc == in_rb) ? wb_data : rf_b;
`else
    // No forwarding: a dependent op waits until the file holds the new value.
    assign busy_eff   = busy_q;
    assign opnd_a     = rf_a;
    assign opnd_b_reg = rf_b;
`endif

    assign opnd_b = in_lit_valid ? {{(XLEN-8){1'b0}}, in_lit} : opnd_b_reg;

    // Busy on rc is the write-after-write stall; R31 is never marked busy.
    assign hazard = busy_eff[in_ra] | (~in_lit_valid & busy_eff[in_rb]) | busy_eff[in_rc];

    assign in_ready = ~reset & (~valid_q | out_ready) & ~hazard;
    assign accept   = in_valid & in_ready;
    assign set_mask = (accept && in_rc != REG_ZERO) ? (NREGS'(1) << in_rc) : '0;

    always_comb begin
        busy_d  = (busy_q & ~clr_mask) | set_mask;
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        rc_d    = rc_q;
        if (accept) begin
            valid_d = 1'b1;
            a_d     = opnd_a;
            b_d     = opnd_b;
            ctrl_d  = in_control;
            rc_d    = in_rc;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            rc_q    <= '0;
        end else begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            rc_q    <= rc_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_a       = a_q;
    assign out_b       = b_q;
    assign out_control = ctrl_q;
    assign out_rc      = rc_q;

endmodule

// File: tb/tb_ibox_operand_stage.sv
// Directed bench for ibox_operand_stage; expectations follow IBOX_BYPASS_EN when defined.
module tb_ibox_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_ra, in_rb, in_rc;
    logic        in_lit_valid;
    logic [7:0]  in_lit;
    logic [31:0] in_control;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_a, out_b;
    logic [31:0] out_control;
    logic [4:0]  out_rc;
    logic        wb_valid;
    logic [4:0]  wb_rc;
    logic [63:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ibox_operand_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ra        (in_ra),
        .in_rb        (in_rb),
        .in_rc        (in_rc),
        .in_lit_valid (in_lit_valid),
        .in_lit       (in_lit),
        .in_control   (in_control),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_control  (out_control),
        .out_rc       (out_rc),
        .wb_valid     (wb_valid),
        .wb_rc        (wb_rc),
        .wb_data      (wb_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc,
                         input logic lv, input logic [7:0] lit, input logic [31:0] ctl);
        in_valid     = 1'b1;
        in_ra        = ra;
        in_rb        = rb;
        in_rc        = rc;
        in_lit_valid = lv;
        in_lit       = lit;
        in_control   = ctl;
        #1;
    endtask

    task automatic wb(input logic v, input logic [4:0] rc, input logic [63:0] d);
        wb_valid = v;
        wb_rc    = rc;
        wb_data  = d;
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_ra = '0; in_rb = '0; in_rc = '0;
        in_lit_valid = 1'b0; in_lit = '0; in_control = '0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rc = '0; wb_data = '0;

        // Reset
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_a", out_a, 0);
        check("rst_out_b", out_b, 0);
        check("rst_out_control", out_control, 0);
        check("rst_out_rc", out_rc, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0; #1;
        check("post_rst_in_ready", in_ready, 1);

        // Independent issue
        wb(1, 1, 64'd5); tick();
        wb(1, 2, 64'd7); tick();
        wb(0, 0, 0);
        offer(1, 2, 3, 0, 0, 32'hA5A5_0001);
        check("ind_in_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
        check("ind_out_valid", out_valid, 1);
        check("ind_out_a", out_a, 64'd5);
        check("ind_out_b", out_b, 64'd7);
        check("ind_out_rc", out_rc, 3);
        check("ind_out_control", out_control, 32'hA5A5_0001);
        offer(3, 31, 31, 0, 0, 0); in_valid = 1'b0;
        check("r3_busy", in_ready, 0);

        // Literal
        offer(31, 9, 4, 1, 8'hFF, 32'h0000_00B2);
        check("lit_in_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
        check("lit_out_a", out_a, 0);
        check("lit_out_b", out_b, 64'hFF);
        check("lit_out_rc", out_rc, 4);

        // Read-after-write on R3
        offer(3, 31, 6, 0, 0, 32'h0000_00C1);
        check("raw_stall0", in_ready, 0);
        tick();
        check("raw_stall1", in_ready, 0);
        wb(1, 3, 64'h1234);
`ifdef IBOX_BYPASS_EN
        check("raw_wb_cycle_ready", in_ready, 1);
        tick(); wb(0, 0, 0); in_valid = 1'b0;
`else
        check("raw_wb_cycle_ready", in_ready, 0);
        tick(); wb(0, 0, 0);
        check("raw_after_wb_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
`endif
        check("raw_out_a", out_a, 64'h1234);
        check("raw_out_rc", out_rc, 6);

        // Backpressure, then back-to-back with no bubble
        out_ready = 1'b0;
        offer(1, 2, 7, 0, 0, 32'h0000_00C2);
        check("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_a", out_a, 64'h1234);
            check("bp_hold_rc", out_rc, 6);
            check("bp_hold_ctrl", out_control, 32'h0000_00C1);
            check("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1; #1;
        check("bp_release_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
        check("b2b_out_valid", out_valid, 1);
        check("b2b_out_a", out_a, 64'd5);
        check("b2b_out_b", out_b, 64'd7);
        check("b2b_out_rc", out_rc, 7);
        check("b2b_out_ctrl", out_control, 32'h0000_00C2);
        tick();
        check("drain_out_valid", out_valid, 0);

        // Write-after-write on R5
        offer(1, 2, 5, 0, 0, 32'h0000_00D1);
        check("waw_first_ready", in_ready, 1);
        tick();
        offer(1, 2, 5, 0, 0, 32'h0000_00D2);
        check("waw_stall0", in_ready, 0);
        tick();
        check("waw_stall1", in_ready, 0);
        wb(1, 5, 64'h55);
`ifdef IBOX_BYPASS_EN
        check("waw_wb_cycle_ready", in_ready, 1);
        tick(); wb(0, 0, 0); in_valid = 1'b0;
`else
        check("waw_wb_cycle_ready", in_ready, 0);
        tick(); wb(0, 0, 0);
        check("waw_after_wb_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
`endif
        check("waw_out_rc", out_rc, 5);
        check("waw_out_ctrl", out_control, 32'h0000_00D2);

        // Zero register: write to R31 alongside a read of R31
        wb(1, 31, 64'd9);
        offer(31, 31, 31, 0, 0, 32'h0000_00E1);
        check("zero_ready", in_ready, 1);
        tick(); wb(0, 0, 0); in_valid = 1'b0;
        wb(1, 31, 64'd9); tick(); wb(0, 0, 0);
        offer(31, 31, 31, 0, 0, 32'h0000_00E2);
        check("zero_not_busy", in_ready, 1);
        tick(); in_valid = 1'b0;
        check("zero_out_a", out_a, 0);
        check("zero_out_b", out_b, 0);
        check("zero_out_rc", out_rc, 31);

        // Reset mid-operation: held instruction dropped, writeback still lands
        offer(1, 2, 10, 0, 0, 32'h0000_00F1);
        tick(); in_valid = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        wb(1, 8, 64'hABCD);
        tick();
        reset = 1'b0; wb(0, 0, 0); out_ready = 1'b1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_a", out_a, 0);
        check("mid_rst_out_rc", out_rc, 0);
        // R5 was busy before reset; busy bits must be cleared
        offer(8, 5, 5, 0, 0, 32'h0000_00F2);
        check("mid_rst_busy_clear", in_ready, 1);
        tick(); in_valid = 1'b0;
        check("mid_rst_wb_a", out_a, 64'hABCD);
        check("mid_rst_r5_b", out_b, 64'h55);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
